// File: rtl/run_skip_multiplier_if.sv
// Handshake and operand/result bundle for run_skip_multiplier.
// The master drives the request; the slave (the multiplier) returns status and result.
interface run_skip_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                          start;
  logic                          signed_mode;
  logic [WIDTH-1:0]              a;
  logic [WIDTH-1:0]              b;
  logic                          busy;
  logic                          done;
  logic [2*WIDTH-1:0]            product;
  logic [$clog2(WIDTH+2)-1:0]    op_count;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product, op_count
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product, op_count
  );
endinterface

// File: rtl/run_skip_multiplier.sv
// Iterative multiplier that spends one add/subtract per transition between bit runs of b
// (radix-2 Booth recoding with zero-run skipping); works for unsigned and two's complement operands.
module run_skip_multiplier #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  run_skip_multiplier_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int TW = WIDTH + 1;
  localparam int IW = $clog2(TW);
  localparam int CW = $clog2(WIDTH + 2);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] a_ext_q, a_ext_d;
  logic [TW-1:0] b_q, b_d;
  logic [TW-1:0] t_q, t_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] product_q, product_d;
  logic [CW-1:0] op_count_q, op_count_d;
  logic          done_q, done_d;

  logic [IW-1:0] sel_idx;
  logic [PW-1:0] addend;
  logic [PW-1:0] acc_step;
  logic [TW-1:0] t_step;

  // Lowest set transition bit: scan downward so the lowest index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      sel_idx = t_q[i] ? IW'(i) : sel_idx;
    end
  end

  // One Booth step: b_q[WIDTH] is held at zero, so the top unsigned transition always adds.
  always_comb begin
    addend   = a_ext_q << sel_idx;
    acc_step = b_q[sel_idx] ? (acc_q - addend) : (acc_q + addend);
    t_step   = t_q & ~(TW'(1) << sel_idx);
  end

  // Next-state logic for the IDLE/RUN controller and datapath.
  always_comb begin
    state_d    = state_q;
    a_ext_d    = a_ext_q;
    b_d        = b_q;
    t_d        = t_q;
    acc_d      = acc_q;
    product_d  = product_q;
    op_count_d = op_count_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_ext_d    = bus.signed_mode ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a}
                                       : {{WIDTH{1'b0}}, bus.a};
          b_d        = {1'b0, bus.b};
          t_d        = {(~bus.signed_mode) & bus.b[WIDTH-1],
                        bus.b ^ {bus.b[WIDTH-2:0], 1'b0}};
          acc_d      = '0;
          op_count_d = '0;
          state_d    = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (t_q == '0) begin
          // b was zero: one empty cycle, then report the cleared accumulator.
          product_d = acc_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          acc_d      = acc_step;
          t_d        = t_step;
          op_count_d = op_count_q + CW'(1);
          if (t_step == '0) begin
            product_d = acc_step;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_ext_q    <= '0;
      b_q        <= '0;
      t_q        <= '0;
      acc_q      <= '0;
      product_q  <= '0;
      op_count_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_ext_q    <= a_ext_d;
      b_q        <= b_d;
      t_q        <= t_d;
      acc_q      <= acc_d;
      product_q  <= product_d;
      op_count_q <= op_count_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = done_q;
  assign bus.product  = product_q;
  assign bus.op_count = op_count_q;
endmodule

// File: tb/tb_run_skip_multiplier.sv
// Scoreboard bench: directed WIDTH=8 vectors plus randomised WIDTH=4/16 runs against a reference model.
module tb_run_skip_multiplier;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  run_skip_multiplier_if #(.WIDTH(8))  bus8  ();
  run_skip_multiplier_if #(.WIDTH(4))  bus4  ();
  run_skip_multiplier_if #(.WIDTH(16)) bus16 ();

  run_skip_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  run_skip_multiplier #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  run_skip_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct {
    longint prod;
    int     ops;
    int     cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  exp_t q16[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint ref_prod(input int w, input bit sm, input longint a, input longint b);
    longint sa = a;
    longint sb = b;
    longint m  = (longint'(1) << (2 * w)) - 1;
    if (sm && a[w-1]) sa = a - (longint'(1) << w);
    if (sm && b[w-1]) sb = b - (longint'(1) << w);
    return (sa * sb) & m;
  endfunction

  function automatic int ref_ops(input int w, input bit sm, input longint b);
    int n    = 0;
    bit prev = 1'b0;
    for (int i = 0; i < w; i++) begin
      if (b[i] != prev) n++;
      prev = b[i];
    end
    if (!sm && b[w-1]) n++;
    return n;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) check("w8_unexpected_done", 1, 0);
      else begin
        e = q8.pop_front();
        check("w8_product", bus8.product, e.prod);
        check("w8_op_count", bus8.op_count, e.ops);
        check("w8_done_cycle", cyc, e.cyc);
      end
    end
    if (bus4.done === 1'b1) begin
      if (q4.size() == 0) check("w4_unexpected_done", 1, 0);
      else begin
        e = q4.pop_front();
        check("w4_product", bus4.product, e.prod);
        check("w4_op_count", bus4.op_count, e.ops);
        check("w4_done_cycle", cyc, e.cyc);
      end
    end
    if (bus16.done === 1'b1) begin
      if (q16.size() == 0) check("w16_unexpected_done", 1, 0);
      else begin
        e = q16.pop_front();
        check("w16_product", bus16.product, e.prod);
        check("w16_op_count", bus16.op_count, e.ops);
        check("w16_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                        input longint prod, input int ops, input int lat);
    exp_t e;
    e.prod = prod;
    e.ops  = ops;
    e.cyc  = cyc + 1 + lat;
    q8.push_back(e);
    bus8.start       = 1'b1;
    bus8.signed_mode = sm;
    bus8.a           = a;
    bus8.b           = b;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus8.busy || bus4.busy || bus16.busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("idle_timeout", 1, 0);
  endtask

  initial begin
    exp_t e;
    int   n;
    bit   sm;
    logic [3:0]  a4, b4;
    logic [15:0] a16, b16;

    rst = 1'b1;
    bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    bus4.start  = 1'b0; bus4.signed_mode  = 1'b0; bus4.a  = '0; bus4.b  = '0;
    bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.a = '0; bus16.b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", bus8.busy, 0);
    check("reset_done", bus8.done, 0);
    check("reset_product", bus8.product, 0);
    check("reset_op_count", bus8.op_count, 0);
    rst = 1'b0;
    @(negedge clk);

    issue8(1'b0, 8'h03, 8'h0F, 64'h002D, 2, 2); wait_idle();
    issue8(1'b0, 8'h03, 8'hFF, 64'h02FD, 2, 2); wait_idle();
    issue8(1'b1, 8'h03, 8'hFF, 64'hFFFD, 1, 1); wait_idle();
    issue8(1'b1, 8'h80, 8'h80, 64'h4000, 1, 1); wait_idle();
    issue8(1'b0, 8'h80, 8'h55, 64'h2A80, 8, 8); wait_idle();
    issue8(1'b1, 8'hFD, 8'hFB, 64'h000F, 3, 3); wait_idle();
    issue8(1'b0, 8'hFF, 8'hFF, 64'hFE01, 2, 2); wait_idle();

    // b=0 with a start pulse during its single RUN cycle: the pulse must be ignored.
    issue8(1'b0, 8'h5A, 8'h00, 64'h0000, 0, 1);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    check("ignored_start_busy", bus8.busy, 0);

    // Start pulse in the middle of a long operation.
    issue8(1'b0, 8'h07, 8'h55, 64'h0253, 8, 8);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h0F;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_idle();

    // Start in the done cycle is accepted immediately.
    issue8(1'b0, 8'h02, 8'h03, 64'h0006, 2, 2);
    wait_idle();
    check("done_cycle_done", bus8.done, 1);
    issue8(1'b0, 8'h05, 8'h01, 64'h0005, 2, 2);
    check("done_cycle_accept_busy", bus8.busy, 1);
    wait_idle();

    // Reset at E0+3 of a b=0x55 operation abandons it.
    bus8.start = 1'b1; bus8.signed_mode = 1'b0; bus8.a = 8'h01; bus8.b = 8'h55;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus8.busy, 0);
    check("abort_done", bus8.done, 0);
    check("abort_product", bus8.product, 0);
    check("abort_op_count", bus8.op_count, 0);
    repeat (10) @(negedge clk);
    check("abort_no_late_done", bus8.done, 0);

    for (int k = 0; k < 24; k++) begin
      sm  = k[0];
      a4  = 4'($urandom);
      b4  = (k == 2) ? 4'h0 : 4'($urandom);
      a16 = 16'($urandom);
      b16 = (k == 5) ? 16'h0000 : 16'($urandom);
      n = ref_ops(4, sm, longint'(b4));
      e.prod = ref_prod(4, sm, longint'(a4), longint'(b4));
      e.ops  = n;
      e.cyc  = cyc + 1 + ((n > 1) ? n : 1);
      q4.push_back(e);
      n = ref_ops(16, sm, longint'(b16));
      e.prod = ref_prod(16, sm, longint'(a16), longint'(b16));
      e.ops  = n;
      e.cyc  = cyc + 1 + ((n > 1) ? n : 1);
      q16.push_back(e);
      bus4.start  = 1'b1; bus4.signed_mode  = sm; bus4.a  = a4;  bus4.b  = b4;
      bus16.start = 1'b1; bus16.signed_mode = sm; bus16.a = a16; bus16.b = b16;
      @(negedge clk);
      bus4.start  = 1'b0;
      bus16.start = 1'b0;
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("queues_drained", q8.size() + q4.size() + q16.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
